// File: rtl/life_pkg.sv
// life_pkg: shared definitions for the Game of Life torus engine.
//   - default grid dimensions
//   - B3/S23 rule masks, indexed by the live-neighbour count n (0..8)
//   - cell_idx(): flat bit index of cell (x, y) in the grid vector
package life_pkg;

  localparam int TORUS_WIDTH_DEF  = 32;
  localparam int TORUS_HEIGHT_DEF = 32;

  // Bit n set means "n live neighbours gives a live cell next generation".
  localparam logic [8:0] BIRTH_MASK   = 9'b000001000;  // born with exactly 3
  localparam logic [8:0] SURVIVE_MASK = 9'b000001100;  // survives with 2 or 3

  // Row-major flat index: bit = y*width + x.
  function automatic int cell_idx(input int x, input int y,
                                  input int width = TORUS_WIDTH_DEF);
    return y * width + x;
  endfunction

endpackage

// File: rtl/life_cell.sv
// life_cell: next-state rule for a single cell.
// Ports:
//   alive  in  current state of this cell
//   nbrs   in  the 8 neighbour states (order irrelevant)
//   next   out state of this cell in the next generation
module life_cell
  import life_pkg::*;
(
  input  logic       alive,
  input  logic [7:0] nbrs,
  output logic       next
);

  logic [3:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(nbrs[i]);
    end
    next = alive ? SURVIVE_MASK[n] : BIRTH_MASK[n];
  end

endmodule

// File: rtl/life_torus.sv
// life_torus: Conway B3/S23 engine over a TORUS_WIDTH x TORUS_HEIGHT
// wrap-around grid, all cells updated in parallel.
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   seed         serial seed bit, qualified by seed_ena
//   seed_ena     shift seed into grid this cycle (has priority over life_step)
//   life_step    compute one generation per cycle it is high
//   torus_state  grid contents, bit y*TORUS_WIDTH + x, 1 = alive
//   torus_last   last executed step produced no change
//   seed_done    one-cycle pulse after every N-th seed bit of a burst
//
// Seed handshake: there is no backpressure. seed is consumed on every
// cycle seed_ena is high; seed_done is a status pulse, not a ready, and is
// high in the cycle after the edge that shifted the N-th bit of a burst.
module life_torus
  import life_pkg::*;
#(
  parameter int TORUS_WIDTH  = TORUS_WIDTH_DEF,
  parameter int TORUS_HEIGHT = TORUS_HEIGHT_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                seed,
  input  logic                                seed_ena,
  input  logic                                life_step,
  output logic [TORUS_WIDTH*TORUS_HEIGHT-1:0] torus_state,
  output logic                                torus_last,
  output logic                                seed_done
);

  localparam int N  = TORUS_WIDTH * TORUS_HEIGHT;
  localparam int CW = $clog2(N) + 1;

  logic [N-1:0]  grid;
  logic [N-1:0]  next_grid;
  logic [CW-1:0] load_cnt;
  logic          load_fresh;  // next seed_ena starts a new burst
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_inc;
  logic          do_step;

  assign torus_state = grid;
  assign do_step     = life_step & ~seed_ena;

  // One rule cell per grid position; neighbour indices wrap mod W and mod H.
  for (genvar gy = 0; gy < TORUS_HEIGHT; gy++) begin : g_row
    for (genvar gx = 0; gx < TORUS_WIDTH; gx++) begin : g_col
      localparam int XL = (gx + TORUS_WIDTH - 1) % TORUS_WIDTH;
      localparam int XR = (gx + 1) % TORUS_WIDTH;
      localparam int YU = (gy + TORUS_HEIGHT - 1) % TORUS_HEIGHT;
      localparam int YD = (gy + 1) % TORUS_HEIGHT;
      localparam int IC = cell_idx(gx, gy, TORUS_WIDTH);

      logic [7:0] nbrs;

      assign nbrs = {grid[cell_idx(XL, YU, TORUS_WIDTH)],
                     grid[cell_idx(gx, YU, TORUS_WIDTH)],
                     grid[cell_idx(XR, YU, TORUS_WIDTH)],
                     grid[cell_idx(XL, gy, TORUS_WIDTH)],
                     grid[cell_idx(XR, gy, TORUS_WIDTH)],
                     grid[cell_idx(XL, YD, TORUS_WIDTH)],
                     grid[cell_idx(gx, YD, TORUS_WIDTH)],
                     grid[cell_idx(XR, YD, TORUS_WIDTH)]};

      life_cell u_cell (
        .alive (grid[IC]),
        .nbrs  (nbrs),
        .next  (next_grid[IC])
      );
    end
  end

  // The first seed_ena after a step or reset restarts the count at bit 0.
  always_comb begin
    cnt_base = load_fresh ? '0 : load_cnt;
    cnt_inc  = cnt_base + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grid       <= '0;
      torus_last <= 1'b0;
      seed_done  <= 1'b0;
      load_cnt   <= '0;
      load_fresh <= 1'b1;
    end else begin
      seed_done <= 1'b0;
      if (seed_ena) begin
        // First bit of a burst ends up at index 0 after N shifts.
        grid       <= {seed, grid[N-1:1]};
        torus_last <= 1'b0;
        load_fresh <= 1'b0;
        if (cnt_inc == CW'(N)) begin
          load_cnt  <= '0;
          seed_done <= 1'b1;
        end else begin
          load_cnt <= cnt_inc;
        end
      end else if (do_step) begin
        grid       <= next_grid;
        torus_last <= (next_grid == grid);
        load_fresh <= 1'b1;
      end
    end
  end

endmodule
